iram_fetch_unit: RTL and testbench

Instruction fetch stage of the multicycle DLX datapath. Drives the IRAM request handshake (`iram_enable_cu` / `iram_ready_cu`), owns the program counter, and presents the fetched instruction word with its next-PC to the control unit's decode step. Accepts branch/jump redirects from the execute logic. Enters a sticky hang state on IRAM timeout or a misaligned target, so the debug path can report `hang_error`.

---
 rtl/iram_fetch_if.sv | 27 ++
 rtl/iram_fetch_unit.sv | 111 +++++++++++
 tb/tb_iram_fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/iram_fetch_if.sv
// Fetch-side bus bundle: IRAM request/response pair and the instruction hand-off to decode.
// Both handshakes complete on a rising edge where the producer's flag (iram_ready_cu / ir_valid)
// and the consumer's flag (iram_enable_cu / ir_ready) are high together.
interface iram_fetch_if #(
    parameter int NUMBIT = 32
);
    logic              iram_enable_cu;
    logic [NUMBIT-1:0] iram_address;
    logic              iram_ready_cu;
    logic [NUMBIT-1:0] iram_data;
    logic              update_pc_branch;
    logic [NUMBIT-1:0] branch_target;
    logic              ir_valid;
    logic              ir_ready;
    logic [NUMBIT-1:0] ir;
    logic [NUMBIT-1:0] npc;

    modport master (
        output iram_enable_cu, iram_address, ir_valid, ir, npc,
        input  iram_ready_cu, iram_data, update_pc_branch, branch_target, ir_ready
    );

    modport slave (
        input  iram_enable_cu, iram_address, ir_valid, ir, npc,
        output iram_ready_cu, iram_data, update_pc_branch, branch_target, ir_ready
    );
endinterface

// File: rtl/iram_fetch_unit.sv
// DLX fetch stage: owns the PC, requests words from IRAM, hands them to decode, hangs on faults.
// Optional FETCH_PERF_CNT_EN adds a fetch_count output counting accepted IRAM responses.
module iram_fetch_unit #(
    parameter int                 NUMBIT   = 32,
    parameter logic [NUMBIT-1:0]  PC_RESET = '0,
    parameter int                 TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    iram_fetch_if.master      bus,
    output logic              hang_error,
    output logic [1:0]        fetch_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [NUMBIT-1:0] fetch_count
`endif
);
    typedef enum logic [1:0] {
        ST_HANG   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2
    } fetch_state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    fetch_state_t      state;
    logic [NUMBIT-1:0] pc;
    logic [NUMBIT-1:0] ir_q;
    logic [NUMBIT-1:0] npc_q;
    logic              ir_valid_q;
    logic [CW-1:0]     wait_cnt;
    // Low for the first cycle after reset so a stale response cannot be captured.
    logic              armed;
`ifdef FETCH_PERF_CNT_EN
    logic [NUMBIT-1:0] fetch_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FETCH;
            pc         <= PC_RESET;
            ir_q       <= '0;
            npc_q      <= '0;
            ir_valid_q <= 1'b0;
            hang_error <= 1'b0;
            wait_cnt   <= '0;
            armed      <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q <= '0;
`endif
        end else begin
            armed <= 1'b1;
            if (state != ST_HANG && bus.update_pc_branch) begin
                ir_valid_q <= 1'b0;
                wait_cnt   <= '0;
                if (bus.branch_target[1:0] != 2'b00) begin
                    state      <= ST_HANG;
                    hang_error <= 1'b1;
                end else begin
                    state <= ST_FETCH;
                    pc    <= bus.branch_target;
                end
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (armed) begin
                            if (bus.iram_ready_cu) begin
                                ir_q       <= bus.iram_data;
                                npc_q      <= pc + NUMBIT'(4);
                                pc         <= pc + NUMBIT'(4);
                                ir_valid_q <= 1'b1;
                                wait_cnt   <= '0;
                                state      <= ST_DECODE;
`ifdef FETCH_PERF_CNT_EN
                                fetch_cnt_q <= fetch_cnt_q + NUMBIT'(1);
`endif
                            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                                state      <= ST_HANG;
                                hang_error <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + CW'(1);
                            end
                        end
                    end
                    ST_DECODE: begin
                        if (bus.ir_ready) begin
                            ir_valid_q <= 1'b0;
                            state      <= ST_FETCH;
                        end
                    end
                    default: begin
                        // HANG is sticky; only reset leaves it.
                        ir_valid_q <= 1'b0;
                        hang_error <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.iram_address   = pc;
    assign bus.iram_enable_cu = armed && (state == ST_FETCH);
    assign bus.ir_valid       = ir_valid_q;
    assign bus.ir             = ir_q;
    assign bus.npc            = npc_q;
    assign fetch_state        = state;
`ifdef FETCH_PERF_CNT_EN
    assign fetch_count        = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_iram_fetch_unit.sv
// Directed plus randomized bench for iram_fetch_unit against a transaction-level fetch model.
module tb_iram_fetch_unit;
    localparam int TO = 16;

    logic clk;
    logic rst;
    logic hang_error;
    logic [1:0] fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    iram_fetch_if #(.NUMBIT(32)) bus ();

    iram_fetch_unit #(.NUMBIT(32), .PC_RESET(32'h0), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .hang_error  (hang_error),
        .fetch_state (fetch_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what the fetch stage is doing, in terms of "instruction held / waiting / hung".
    logic [31:0] m_pc, m_ir, m_npc, m_count;
    bit          m_held, m_hung, m_armed;
    int          m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input logic [31:0] d,
                              input bit br, input logic [31:0] tgt, input bit irr);
        bit was_armed;
        if (!r) begin
            m_pc = 32'h0; m_ir = 0; m_npc = 0; m_held = 0; m_hung = 0;
            m_wait = 0; m_armed = 0; m_count = 0;
        end else if (!m_hung) begin
            was_armed = m_armed;
            m_armed = 1;
            if (br) begin
                m_held = 0;
                m_wait = 0;
                if (tgt % 4 != 0) m_hung = 1;
                else m_pc = tgt;
            end else if (m_held) begin
                if (irr) m_held = 0;
            end else if (was_armed) begin
                if (rdy) begin
                    m_ir = d; m_npc = m_pc + 4; m_pc = m_pc + 4;
                    m_held = 1; m_wait = 0; m_count = m_count + 1;
                end else begin
                    m_wait++;
                    if (m_wait == TO) m_hung = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_state;
        exp_state = m_hung ? 0 : (m_held ? 2 : 1);
        check("iram_address", bus.iram_address, m_pc);
        check("iram_enable_cu", 32'(bus.iram_enable_cu), 32'(m_armed && !m_held && !m_hung));
        check("ir_valid", 32'(bus.ir_valid), 32'(m_held));
        check("ir", bus.ir, m_ir);
        check("npc", bus.npc, m_npc);
        check("hang_error", 32'(hang_error), 32'(m_hung));
        check("fetch_state", 32'(fetch_state), exp_state);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_count);
`endif
    endtask

    // One clock: apply inputs, advance DUT and model on the edge, compare 1ns later.
    task automatic cyc(input bit r, input bit rdy, input logic [31:0] d,
                       input bit br, input logic [31:0] tgt, input bit irr);
        rst = r;
        bus.iram_ready_cu    = rdy;
        bus.iram_data        = d;
        bus.update_pc_branch = br;
        bus.branch_target    = tgt;
        bus.ir_ready         = irr;
        @(posedge clk);
        model_step(r, rdy, d, br, tgt, irr);
        #1;
        compare_all();
    endtask

    initial begin
        int pct;
        logic [31:0] tgt;
        rst = 0;
        bus.iram_ready_cu = 0; bus.iram_data = 0; bus.update_pc_branch = 0;
        bus.branch_target = 0; bus.ir_ready = 0;
        model_step(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset state
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_enable", 32'(bus.iram_enable_cu), 0);
        check("rst_state", 32'(fetch_state), 1);

        // Back-to-back fetch, one instruction per two cycles
        cyc(1, 0, 0, 0, 0, 0);
        check("first_req_addr", bus.iram_address, 32'h0);
        check("first_req_en", 32'(bus.iram_enable_cu), 1);
        cyc(1, 1, 32'h2001_0005, 0, 0, 1);
        check("first_ir", bus.ir, 32'h2001_0005);
        check("first_npc", bus.npc, 32'h4);
        cyc(1, 1, 32'h2001_0005, 0, 0, 1);
        check("second_req_addr", bus.iram_address, 32'h4);
        cyc(1, 1, 32'h2001_0005, 0, 0, 1);
        cyc(1, 1, 32'h2001_0005, 0, 0, 1);
        check("third_req_addr", bus.iram_address, 32'h8);

        // Delayed response, then timeout into HANG
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("wait_addr", bus.iram_address, 32'h8);
        end
        cyc(1, 1, 32'h1111_2222, 0, 0, 0);
        check("late_ir", bus.ir, 32'h1111_2222);
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0, 0, 0);
        check("no_hang_at_15", 32'(hang_error), 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("hang_at_16", 32'(hang_error), 1);
        check("hang_state", 32'(fetch_state), 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'h5, i[0], 32'h40, 1);
        check("hang_sticky", 32'(hang_error), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("hang_cleared", 32'(hang_error), 0);

        // Redirect beats a same-cycle response; misaligned target hangs
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'hAAAA_5555, 1, 32'h100, 0);
        check("redir_valid", 32'(bus.ir_valid), 0);
        check("redir_addr", bus.iram_address, 32'h100);
        check("redir_en", 32'(bus.iram_enable_cu), 1);
        cyc(1, 1, 32'h3333_4444, 0, 0, 0);
        check("redir_npc", bus.npc, 32'h104);
        cyc(1, 0, 0, 1, 32'h102, 0);
        check("misalign_hang", 32'(hang_error), 1);
        check("misalign_pc", bus.iram_address, 32'h104);
        cyc(0, 0, 0, 0, 0, 0);

        // PC wrap
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 1, 32'h0BAD_F00D, 0, 0, 0);
        check("wrap_npc", bus.npc, 32'h0);
        cyc(1, 0, 0, 0, 0, 1);
        check("wrap_addr", bus.iram_address, 32'h0);
        check("wrap_no_err", 32'(hang_error), 0);

        // Reset mid-FETCH and mid-DECODE
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_fetch_pc", bus.iram_address, 32'h0);
        cyc(1, 1, 32'h7777_7777, 0, 0, 0);
        check("rst_stale_ignored", 32'(bus.ir_valid), 0);
        cyc(1, 1, 32'h8888_8888, 0, 0, 0);
        cyc(0, 1, 32'h9999_9999, 0, 0, 0);
        check("rst_decode_valid", 32'(bus.ir_valid), 0);
        check("rst_decode_ir", bus.ir, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        check("post_rst_req", 32'(bus.iram_enable_cu), 1);

`ifdef FETCH_PERF_CNT_EN
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 32'(i), 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 1);
        end
        cyc(1, 1, 32'hFFFF, 1, 32'h200, 0);
        check("perf_count_5", fetch_count, 32'd5);
`endif

        // Randomized traffic
        pct = 70;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) pct = $urandom_range(0, 100);
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFFC;
            cyc($urandom_range(0, 59) != 0,
                $urandom_range(1, 100) <= pct,
                $urandom,
                $urandom_range(0, 19) == 0,
                tgt,
                $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
